// File: rtl/uio_bus_arbiter_pkg.sv
// Shared constants for the uio pad-bus arbiter: FSM encodings, default sizing and pad-enable codes.
package uio_arb_pkg;

    localparam int unsigned DefNReq       = 3;
    localparam int unsigned DefMaxBurst   = 4;
    localparam int unsigned DefTurnaround = 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StOwn  = 2'd1;
    localparam logic [1:0] StTurn = 2'd2;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_HIZ   = 8'h00;

    // Index width that stays legal (>= 1 bit) for any requester count.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned PW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             valid_o
);

    always_comb begin
        logic [PW-1:0] j;
        pick_o  = '0;
        valid_o = 1'b0;
        j       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = PW'((int'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[j]) begin
                pick_o[j] = 1'b1;
                valid_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with bounded bursts and a pad turnaround gap.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = DefNReq,
    parameter int unsigned MAX_BURST  = DefMaxBurst,
    parameter int unsigned TURNAROUND = DefTurnaround
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   wr,
    input  logic [8*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic               busy,
    input  logic [7:0]         uio_in,
    output logic [7:0]         uio_out,
    output logic [7:0]         uio_oe
);

    localparam int unsigned PW = idx_width(N_REQ);

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             dir_q, dir_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       turn_q, turn_d;
    logic [7:0]       uio_out_q, uio_out_d;
    logic [7:0]       uio_oe_q, uio_oe_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic [N_REQ-1:0] pick_oh;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic             beat;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick_oh),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_oh[i]) pick_idx = PW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        grant_d    = grant_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        turn_d     = turn_q;
        uio_out_d  = uio_out_q;
        uio_oe_d   = uio_oe_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        beat       = 1'b0;
        case (state_q)
            StIdle: begin
                if (ena && pick_valid) begin
                    grant_d  = pick_oh;
                    owner_d  = pick_idx;
                    dir_d    = wr[pick_idx];
                    uio_oe_d = wr[pick_idx] ? OE_DRIVE : OE_HIZ;
                    cnt_d    = '0;
                    state_d  = StOwn;
                end
            end
            StOwn: begin
                beat = req[owner_q];
                if (beat) begin
                    cnt_d = cnt_q + 4'd1;
                    if (dir_q) begin
                        uio_out_d = wdata[{owner_q, 3'b000} +: 8];
                    end else begin
                        rd_data_d  = uio_in;
                        rd_valid_d = 1'b1;
                    end
                end
                // A losing ena still lets the current beat complete before release.
                if (!beat || (cnt_q + 4'd1 == 4'(MAX_BURST)) || !ena) begin
                    grant_d  = '0;
                    uio_oe_d = OE_HIZ;
                    ptr_d    = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    turn_d   = '0;
                    state_d  = StTurn;
                end
            end
            StTurn: begin
                if (turn_q == 2'(TURNAROUND - 1)) begin
                    state_d = StIdle;
                end else begin
                    turn_d = turn_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            grant_q    <= '0;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            turn_q     <= '0;
            uio_out_q  <= '0;
            uio_oe_q   <= OE_HIZ;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            grant_q    <= grant_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            turn_q     <= turn_d;
            uio_out_q  <= uio_out_d;
            uio_oe_q   <= uio_oe_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign grant    = grant_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != StIdle);
    assign uio_out  = uio_out_q;
    assign uio_oe   = uio_oe_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench: tenure-level reference model plus directed literal checks and random traffic.
module tb_uio_bus_arbiter;

    localparam int N  = 3;
    localparam int MB = 4;
    localparam int TA = 1;

    logic           clk = 1'b0;
    logic           rst, ena;
    logic [N-1:0]   req, wr;
    logic [8*N-1:0] wdata;
    logic [7:0]     uio_in;
    logic [N-1:0]   grant;
    logic [7:0]     rd_data, uio_out, uio_oe;
    logic           rd_valid, busy;

    always #5 clk = ~clk;

    uio_bus_arbiter #(
        .N_REQ      (N),
        .MAX_BURST  (MB),
        .TURNAROUND (TA)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .req      (req),
        .wr       (wr),
        .wdata    (wdata),
        .grant    (grant),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .uio_in   (uio_in),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = waiting for arbitration, 1 = tenure, 2 = turnaround gap.
    int         m_phase, m_ptr, m_owner, m_beats, m_turn_left;
    bit         m_dir, m_rv;
    logic [N-1:0] m_grant;
    logic [7:0] m_out, m_oe, m_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_owner = 0; m_beats = 0; m_turn_left = 0;
        m_dir = 0; m_rv = 0; m_grant = '0; m_out = '0; m_oe = '0; m_rd = '0;
    endtask

    task automatic model_edge();
        bit beat;
        if (rst) begin
            model_reset();
            return;
        end
        m_rv = 0;
        if (m_phase == 0) begin
            if (ena && req != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_grant = '0;
                m_grant[m_owner] = 1'b1;
                m_dir   = wr[m_owner];
                m_oe    = m_dir ? 8'hFF : 8'h00;
                m_beats = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            beat = req[m_owner];
            if (beat) begin
                m_beats++;
                if (m_dir) m_out = wdata[8*m_owner +: 8];
                else begin
                    m_rd = uio_in;
                    m_rv = 1;
                end
            end
            if (!beat || m_beats == MB || !ena) begin
                m_grant     = '0;
                m_oe        = 8'h00;
                m_ptr       = (m_owner + 1) % N;
                m_turn_left = TA;
                m_phase     = 2;
            end
        end else begin
            m_turn_left--;
            if (m_turn_left == 0) m_phase = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("grant",    32'(grant),    32'(m_grant));
        check("uio_oe",   32'(uio_oe),   32'(m_oe));
        check("uio_out",  32'(uio_out),  32'(m_out));
        check("rd_valid", 32'(rd_valid), 32'(m_rv));
        check("rd_data",  32'(rd_data),  32'(m_rd));
        check("busy",     32'(busy),     32'(m_phase != 0));
    endtask

    task automatic idle_steps(input int n);
        req = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [N-1:0] exp_rot [6];
        logic [N-1:0] prev_g;
        int zero_run, n_grants;

        model_reset();
        rst = 1'b1; ena = 1'b1; req = '0; wr = '0; wdata = '0; uio_in = '0;
        step(); step();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_oe",    32'(uio_oe), 32'h0);
        check("reset_busy",  32'(busy), 32'h0);

        // Single write requester held long enough to exhaust a burst and re-win.
        rst = 1'b0; req = 3'b001; wr = 3'b001; wdata = 24'h0000A5;
        step();
        check("wr_grant", 32'(grant), 32'h1);
        check("wr_oe",    32'(uio_oe), 32'hFF);
        step();
        check("wr_out",   32'(uio_out), 32'hA5);
        step(); step(); step();
        check("burst_release_grant", 32'(grant), 32'h0);
        check("burst_release_oe",    32'(uio_oe), 32'h0);
        step();
        check("turn_oe", 32'(uio_oe), 32'h0);
        step();
        check("regrant_0", 32'(grant), 32'h1);
        idle_steps(6);

        // All three requesting: rotation starts at requester 1, gap of 2 idle-grant cycles.
        exp_rot[0] = 3'b010; exp_rot[1] = 3'b100; exp_rot[2] = 3'b001;
        exp_rot[3] = 3'b010; exp_rot[4] = 3'b100; exp_rot[5] = 3'b001;
        req = 3'b111; wr = 3'b111; wdata = 24'h332211;
        prev_g = '0; zero_run = 0; n_grants = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (grant != '0 && prev_g == '0) begin
                if (n_grants < 6) check("rotation", 32'(grant), 32'(exp_rot[n_grants]));
                if (n_grants > 0) check("gap", 32'(zero_run), 32'd2);
                n_grants++;
            end
            zero_run = (grant == '0) ? zero_run + 1 : 0;
            prev_g = grant;
        end
        check("rotation_count", 32'(n_grants >= 6), 32'd1);
        idle_steps(6);

        // Read tenure for requester 1.
        req = 3'b010; wr = 3'b000;
        step();
        check("rd_grant", 32'(grant), 32'h2);
        uio_in = 8'h3C;
        step();
        check("rd_v1", 32'(rd_valid), 32'h1);
        check("rd_d1", 32'(rd_data), 32'h3C);
        uio_in = 8'h3D;
        step();
        check("rd_v2", 32'(rd_valid), 32'h1);
        check("rd_d2", 32'(rd_data), 32'h3D);
        check("rd_oe", 32'(uio_oe), 32'h0);
        req = '0;
        step();
        check("rd_v_end", 32'(rd_valid), 32'h0);
        idle_steps(4);

        // Direction change mid-tenure is ignored.
        req = 3'b001; wr = 3'b001; wdata = 24'h00005A;
        step(); step();
        wr = 3'b000; wdata = 24'h0000C3;
        step();
        check("wr_hold_oe",  32'(uio_oe), 32'hFF);
        check("wr_hold_out", 32'(uio_out), 32'hC3);
        idle_steps(6);

        // Dropping ena ends the tenure and blocks new grants.
        req = 3'b111; wr = 3'b111;
        step(); step();
        ena = 1'b0;
        step();
        check("ena_release", 32'(grant), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("ena_block", 32'(grant), 32'h0);
        end
        ena = 1'b1;
        idle_steps(6);

        // Reset mid write burst clears everything and the pointer.
        req = 3'b100; wr = 3'b100; wdata = 24'h770000;
        step(); step();
        rst = 1'b1;
        step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_oe",    32'(uio_oe), 32'h0);
        check("rst_out",   32'(uio_out), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        rst = 1'b0; req = 3'b111;
        step();
        check("rst_ptr_grant", 32'(grant), 32'h1);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst    = ($urandom_range(0, 299) == 0);
            ena    = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            wr     = N'($urandom);
            wdata  = 24'($urandom);
            uio_in = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
